// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the single-byte I2C target.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Open drain: a bit value of 0 means we must pull the line low.
  function automatic logic drive_low(input logic level);
    return (level == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and produces edge strobes plus START/STOP detection.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_sync;
  logic                   scl_steady_high;

  // Idle bus is pulled high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_sync;
      sda_prev <= sda_sync;
    end
  end

  assign scl_sync        = scl_pipe[SYNC_STAGES-1];
  assign sda_sync        = sda_pipe[SYNC_STAGES-1];
  assign scl_rise        = scl_sync & ~scl_prev;
  assign scl_fall        = ~scl_sync & scl_prev;
  // A simultaneous SCL change counts only as an SCL edge, never START/STOP.
  assign scl_steady_high = scl_sync & scl_prev;
  assign start_det       = scl_steady_high & sda_prev & ~sda_sync;
  assign stop_det        = scl_steady_high & ~sda_prev & sda_sync;

endmodule

// File: rtl/i2c_slave_single_byte.sv
// I2C target with a fixed address: write bytes are presented to the fabric,
// read bytes are fetched from the fabric. Open drain, no clock stretching.
module i2c_slave_single_byte
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_tx_taken,
  output logic       o_busy,
  output logic       o_error,
  inout  wire        io_scl,
  inout  wire        io_sda
);

  logic scl_rise, scl_fall, sda_sync, start_det, stop_det;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_monitor (
    .clk      (i_clk),
    .rst      (i_rst),
    .scl      (io_scl),
    .sda      (io_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_sync (sda_sync),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       clocked, clocked_n;
  logic [7:0] shreg, shreg_n;
  logic       sda_oe, sda_oe_n;
  logic       busy, busy_n;
  logic [7:0] rx_byte, rx_byte_n;
  logic       rx_valid_n, tx_taken_n, error_n;
  logic [7:0] shifted;
  logic       mid_byte;

  // clocked marks that the current bit's high phase was seen, so the stray
  // SCL fall right after a START is not counted as a completed bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      clocked    <= 1'b0;
      shreg      <= 8'h00;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      rx_byte    <= 8'h00;
      o_rx_valid <= 1'b0;
      o_tx_taken <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      clocked    <= clocked_n;
      shreg      <= shreg_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      rx_byte    <= rx_byte_n;
      o_rx_valid <= rx_valid_n;
      o_tx_taken <= tx_taken_n;
      o_error    <= error_n;
    end
  end

  // Bus conditions outrank SCL edges; bit_cnt counts completed bits (on falls).
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    clocked_n  = clocked;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    rx_byte_n  = rx_byte;
    rx_valid_n = 1'b0;
    tx_taken_n = 1'b0;
    error_n    = 1'b0;
    shifted    = {shreg[6:0], sda_sync};
    mid_byte   = (state inside {ADDR, RX_DATA, TX_DATA}) && (bit_cnt != 3'd0);

    if (!i_enable) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
      clocked_n = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      error_n   = mid_byte;
      bit_cnt_n = 3'd0;
      clocked_n = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      sda_oe_n  = 1'b0;
      error_n   = mid_byte;
      bit_cnt_n = 3'd0;
      clocked_n = 1'b0;
    end else if (scl_rise) begin
      clocked_n = 1'b1;
      case (state)
        ADDR: begin
          shreg_n = shifted;
          if (bit_cnt == 3'd7 && shifted[7:1] != SLAVE_ADDR) begin
            state_n   = WAIT_STOP;
            busy_n    = 1'b0;
            clocked_n = 1'b0;
          end
        end
        RX_DATA: begin
          shreg_n = shifted;
          if (bit_cnt == 3'd7) begin
            rx_byte_n  = shifted;
            rx_valid_n = 1'b1;
          end
        end
        TX_ACK: begin
          if (sda_sync == NACK) begin
            state_n   = WAIT_STOP;
            clocked_n = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (scl_fall && clocked) begin
      clocked_n = 1'b0;
      case (state)
        ADDR, RX_DATA: begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = 3'd0;
            sda_oe_n  = drive_low(ACK);
            state_n   = (state == ADDR) ? ADDR_ACK : RX_ACK;
            if (state == ADDR) busy_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        ADDR_ACK, TX_ACK: begin
          sda_oe_n = 1'b0;
          if (state == ADDR_ACK && !shreg[0]) begin
            state_n = RX_DATA;
          end else begin
            shreg_n    = i_tx_byte;
            tx_taken_n = 1'b1;
            sda_oe_n   = drive_low(i_tx_byte[7]);
            bit_cnt_n  = 3'd0;
            state_n    = TX_DATA;
          end
        end
        RX_ACK: begin
          sda_oe_n = 1'b0;
          state_n  = RX_DATA;
        end
        TX_DATA: begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
            state_n   = TX_ACK;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {shreg[6:0], shreg[7]};
            sda_oe_n  = drive_low(shreg[6]);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_sda    = sda_oe ? 1'b0 : 1'bz;
  assign o_rx_byte = rx_byte;
  assign o_busy    = busy;

endmodule

// File: tb/tb_i2c_slave_single_byte.sv
// Directed bench: acts as the bus master and checks the target against a
// cycle-scheduled protocol model every cycle.
module tb_i2c_slave_single_byte;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;
  localparam int H    = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] rx_byte;
  logic       rx_valid, tx_taken, busy, error;
  logic       mscl = 1'b1;
  logic       msda = 1'b1;
  wire        scl_bus;
  wire        sda_bus;

  assign scl_bus = mscl ? 1'bz : 1'b0;
  assign sda_bus = msda ? 1'bz : 1'b0;
  pullup (scl_bus);
  pullup (sda_bus);

  i2c_slave_single_byte #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(SYNC)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (enable),
    .i_tx_byte (tx_byte),
    .o_rx_byte (rx_byte),
    .o_rx_valid(rx_valid),
    .o_tx_taken(tx_taken),
    .o_busy    (busy),
    .o_error   (error),
    .io_scl    (scl_bus),
    .io_sda    (sda_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected events keyed by the cycle they must be visible.
  logic [7:0] rxEv[int];
  bit         txEv[int];
  bit         errEv[int];
  bit         busyEv[int];
  logic [7:0] modelRx = 8'h00;
  bit         modelBusy = 1'b0;
  bit         chkEn = 1'b0;
  bit         noDrive = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chkEn) begin
      if (rxEv.exists(cyc)) modelRx = rxEv[cyc];
      if (busyEv.exists(cyc)) modelBusy = busyEv[cyc];
      checkOutput("rx_valid", {7'd0, rx_valid}, rxEv.exists(cyc) ? 8'd1 : 8'd0);
      checkOutput("rx_byte", rx_byte, modelRx);
      checkOutput("tx_taken", {7'd0, tx_taken}, txEv.exists(cyc) ? 8'd1 : 8'd0);
      checkOutput("error", {7'd0, error}, errEv.exists(cyc) ? 8'd1 : 8'd0);
      checkOutput("busy", {7'd0, busy}, {7'd0, modelBusy});
      if (noDrive) checkOutput("sda_released", {7'd0, sda_bus}, {7'd0, msda});
    end
  end

  // One SCL clock with the master putting b on SDA (1 = released).
  task automatic clockBit(input bit b, input bit rxEvt, input logic [7:0] rxVal,
                          input bit busyEvt, input bit txEvt, output bit s);
    msda = b;
    repeat (H) @(negedge clk);
    mscl = 1'b1;
    if (rxEvt) rxEv[cyc + LAT] = rxVal;
    repeat (H / 2) @(negedge clk);
    s = sda_bus;
    repeat (H - H / 2) @(negedge clk);
    mscl = 1'b0;
    if (busyEvt) busyEv[cyc + LAT] = 1'b1;
    if (txEvt) txEv[cyc + LAT] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic xferByte(input logic [7:0] val, input bit rxEvt, input bit busyEvt,
                          output logic [7:0] got);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(val[i], rxEvt && i == 0, val, busyEvt && i == 0, 1'b0, s);
      got[i] = s;
    end
  endtask

  task automatic busStart();
    msda = 1'b0;
    repeat (H) @(negedge clk);
    mscl = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic busRestart();
    msda = 1'b1;
    repeat (H) @(negedge clk);
    mscl = 1'b1;
    repeat (H) @(negedge clk);
    msda = 1'b0;
    repeat (H) @(negedge clk);
    mscl = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic busStop(input bit errEvt);
    msda = 1'b0;
    repeat (H) @(negedge clk);
    mscl = 1'b1;
    repeat (H) @(negedge clk);
    msda = 1'b1;
    busyEv[cyc + LAT] = 1'b0;
    if (errEvt) errEv[cyc + LAT] = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic sendAddr(input logic [6:0] addr, input bit rw);
    logic [7:0] got;
    bit s;
    bit match;
    match = (addr == 7'h50);
    xferByte({addr, rw}, 1'b0, match, got);
    clockBit(1'b1, 1'b0, 8'h00, 1'b0, match && rw, s);
    checkOutput("addr_ack", {7'd0, s}, match ? 8'd0 : 8'd1);
  endtask

  task automatic writeByte(input logic [7:0] b);
    logic [7:0] got;
    bit s;
    xferByte(b, 1'b1, 1'b0, got);
    clockBit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, s);
    checkOutput("data_ack", {7'd0, s}, 8'd0);
  endtask

  task automatic readByte(input logic [7:0] want, input bit masterAck);
    logic [7:0] got;
    bit s;
    xferByte(8'hFF, 1'b0, 1'b0, got);
    checkOutput("read_data", got, want);
    clockBit(masterAck, 1'b0, 8'h00, 1'b0, masterAck == 1'b0, s);
    checkOutput("read_ack_line", {7'd0, s}, {7'd0, masterAck});
  endtask

  task automatic applyStimulus(input int testId);
    bit s;
    case (testId)
      0: begin
        busStart(); sendAddr(7'h50, 1'b0); writeByte(8'hA5); busStop(1'b0);
        checkOutput("write_rx_byte", rx_byte, 8'hA5);
        checkOutput("write_busy_after_stop", {7'd0, busy}, 8'd0);
      end
      1: begin
        noDrive = 1'b1;
        busStart(); sendAddr(7'h51, 1'b0); busStop(1'b0);
        noDrive = 1'b0;
        checkOutput("wrong_addr_rx_byte_held", rx_byte, 8'hA5);
      end
      2: begin
        tx_byte = 8'h3C;
        busStart(); sendAddr(7'h50, 1'b1); readByte(8'h3C, 1'b1); busStop(1'b0);
        checkOutput("read_busy_after_stop", {7'd0, busy}, 8'd0);
      end
      3: begin
        busStart(); sendAddr(7'h50, 1'b0);
        writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
        busStop(1'b0);
        checkOutput("multi_last_byte", rx_byte, 8'h33);
      end
      4: begin
        tx_byte = 8'h7E;
        busStart(); sendAddr(7'h50, 1'b0); writeByte(8'h01);
        checkOutput("rs_rx_byte", rx_byte, 8'h01);
        busRestart(); sendAddr(7'h50, 1'b1); readByte(8'h7E, 1'b1); busStop(1'b0);
      end
      5: begin
        busStart(); sendAddr(7'h50, 1'b0);
        clockBit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, s);
        clockBit(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, s);
        clockBit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, s);
        clockBit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, s);
        busStop(1'b1);
        checkOutput("abort_busy", {7'd0, busy}, 8'd0);
      end
      default: begin
        logic [7:0] got;
        busStart(); sendAddr(7'h50, 1'b0);
        xferByte(8'hC3, 1'b1, 1'b0, got);
        msda = 1'b1;
        repeat (H) @(negedge clk);
        mscl = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("ack_before_reset", {7'd0, sda_bus}, 8'd0);
        #3;
        rst = 1'b1;
        modelBusy = 1'b0;
        modelRx = 8'h00;
        #1;
        checkOutput("reset_sda_released", {7'd0, sda_bus}, 8'd1);
        checkOutput("reset_rx_byte", rx_byte, 8'h00);
        checkOutput("reset_busy", {7'd0, busy}, 8'd0);
        checkOutput("reset_rx_valid", {7'd0, rx_valid}, 8'd0);
        checkOutput("reset_tx_taken", {7'd0, tx_taken}, 8'd0);
        checkOutput("reset_error", {7'd0, error}, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mscl = 1'b0;
        repeat (2) @(negedge clk);
        busStop(1'b0);
      end
    endcase
  endtask

  initial begin
    repeat (4) @(negedge clk);
    checkOutput("init_rx_byte", rx_byte, 8'h00);
    checkOutput("init_rx_valid", {7'd0, rx_valid}, 8'd0);
    checkOutput("init_tx_taken", {7'd0, tx_taken}, 8'd0);
    checkOutput("init_busy", {7'd0, busy}, 8'd0);
    checkOutput("init_error", {7'd0, error}, 8'd0);
    checkOutput("init_sda", {7'd0, sda_bus}, 8'd1);
    rst = 1'b0;
    chkEn = 1'b1;
    repeat (4) @(negedge clk);
    for (int t = 0; t <= 6; t++) begin
      applyStimulus(t);
      repeat (4) @(negedge clk);
    end
    chkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
